// File: rtl/qspi_flash_reader.sv
// ----------------------------------------------------------------------------
// qspi_flash_reader
//
// Quad-SPI flash read sequencer for the iCE40 flash SB_IO cells. After reset
// it sends the release-from-deep-power-down command (0xAB), waits, and then
// serves streaming read requests using Fast Read Quad I/O (0xEB). It drives
// the DDR clock pair, chip select, per-pin output enables and output nibbles,
// and assembles 32-bit little-endian words from the registered input nibble.
//
// Parameters
//   DUMMY_CYCLES   SCK cycles between the mode byte and the first data nibble
//   INPUT_LATENCY  clk_2x cycles from a data SCK cycle to its nibble on
//                  flash_out (pad output + input registers), must be >= 1
//   WAKE_DELAY     clk_2x cycles csn stays high after the wake command
//   CSN_HIGH_MIN   minimum clk_2x cycles csn stays high between transactions
//
// Ports
//   clk_2x         sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   req_valid/req_ready/req_addr/req_words
//                  read request handshake; req_words = word count - 1
//   data_valid     one-cycle strobe, no back-pressure
//   data           read word, first byte read in [7:0]
//   busy           inverse of req_ready
//   flash_clk_ddr  [0] first half-cycle, [1] second; 2'b10 is one SCK pulse
//   flash_csn      flash chip select, active low
//   flash_in_en    per-IO output enable, 1 = pad drives
//   flash_in       nibble driven to the pads
//   flash_out      registered pad input nibble
// ----------------------------------------------------------------------------
module qspi_flash_reader #(
    parameter int unsigned DUMMY_CYCLES  = 4,
    parameter int unsigned INPUT_LATENCY = 2,
    parameter int unsigned WAKE_DELAY    = 64,
    parameter int unsigned CSN_HIGH_MIN  = 2
) (
    input  logic        clk_2x,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_words,
    output logic        data_valid,
    output logic [31:0] data,
    output logic        busy,
    output logic [1:0]  flash_clk_ddr,
    output logic        flash_csn,
    output logic [3:0]  flash_in_en,
    output logic [3:0]  flash_in,
    input  logic [3:0]  flash_out
);

    typedef enum logic [3:0] {
        ST_WAKE_CMD,
        ST_WAKE_WAIT,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_e;

    localparam logic [7:0] WAKE_BYTE = 8'hAB;
    localparam logic [7:0] READ_BYTE = 8'hEB;

    localparam logic [1:0] SCK_PULSE = 2'b10;
    localparam logic [1:0] SCK_IDLE  = 2'b00;

    // Single-bit phases drive IO0 and keep WP#/HOLD# (IO2/IO3) driven high.
    localparam logic [3:0] EN_SINGLE = 4'b1101;
    localparam logic [3:0] EN_QUAD   = 4'b1111;
    localparam logic [3:0] EN_NONE   = 4'b0000;

    localparam int unsigned CAP_STAGES = (INPUT_LATENCY == 0) ? 1 : INPUT_LATENCY;

    localparam logic [15:0] WAKE_LAST  = 16'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);
    localparam logic [15:0] DUMMY_LAST = 16'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam logic [15:0] END_HOLD   = 16'((CSN_HIGH_MIN > 0) ? CSN_HIGH_MIN - 1 : 0);

    function automatic logic [3:0] single_io(input logic bit_val);
        return {2'b11, 1'b0, bit_val};
    endfunction

    // ------------------------------------------------------------------
    // Sequencer state and registered pad outputs
    // ------------------------------------------------------------------
    state_e      state_q;
    logic [15:0] cnt_q;        // SCK / wait counter within the current state
    logic [7:0]  sh_q;         // command byte shifter, MSB goes out next
    logic [23:0] addr_q;       // latched address, shifted out a nibble at a time
    logic [7:0]  words_q;      // remaining words minus 1
    logic        req_ready_q;
    logic        csn_q;
    logic [1:0]  sck_q;
    logic [3:0]  en_q;
    logic [3:0]  io_q;

    // ------------------------------------------------------------------
    // Capture pipeline and word assembly
    // ------------------------------------------------------------------
    logic [CAP_STAGES-1:0] cap_vld_q;
    logic [2:0]            cap_idx_q [CAP_STAGES];
    logic                  cap_fire;
    logic [2:0]            cap_sel;
    logic                  cap_last;
    logic [31:0]           asm_q;
    logic [31:0]           asm_d;
    logic [31:0]           data_q;
    logic                  data_valid_q;

    // Each state sets the pad outputs for the following cycle, so the ports
    // always show the phase recorded in state_q with no combinational path.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAKE_CMD;
            cnt_q       <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            req_ready_q <= 1'b0;
            csn_q       <= 1'b1;
            sck_q       <= SCK_IDLE;
            en_q        <= EN_NONE;
            io_q        <= '0;
        end else begin
            case (state_q)
                ST_WAKE_CMD: begin
                    if (csn_q) begin
                        // First cycle after reset: open the wake command.
                        csn_q <= 1'b0;
                        sck_q <= SCK_PULSE;
                        en_q  <= EN_SINGLE;
                        io_q  <= single_io(WAKE_BYTE[7]);
                        sh_q  <= {WAKE_BYTE[6:0], 1'b0};
                        cnt_q <= '0;
                    end else if (cnt_q == 16'd7) begin
                        csn_q       <= 1'b1;
                        sck_q       <= SCK_IDLE;
                        en_q        <= EN_NONE;
                        io_q        <= '0;
                        cnt_q       <= '0;
                        state_q     <= (WAKE_DELAY == 0) ? ST_IDLE : ST_WAKE_WAIT;
                        req_ready_q <= (WAKE_DELAY == 0);
                    end else begin
                        io_q  <= single_io(sh_q[7]);
                        sh_q  <= {sh_q[6:0], 1'b0};
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_WAKE_WAIT: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        words_q     <= req_words;
                        csn_q       <= 1'b0;
                        sck_q       <= SCK_PULSE;
                        en_q        <= EN_SINGLE;
                        io_q        <= single_io(READ_BYTE[7]);
                        sh_q        <= {READ_BYTE[6:0], 1'b0};
                        cnt_q       <= '0;
                        state_q     <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (cnt_q == 16'd7) begin
                        en_q    <= EN_QUAD;
                        io_q    <= addr_q[23:20];
                        addr_q  <= {addr_q[19:0], 4'h0};
                        cnt_q   <= '0;
                        state_q <= ST_ADDR;
                    end else begin
                        io_q  <= single_io(sh_q[7]);
                        sh_q  <= {sh_q[6:0], 1'b0};
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_ADDR: begin
                    if (cnt_q == 16'd5) begin
                        // Mode nibbles of 0 keep the flash out of continuous-read mode.
                        io_q    <= 4'h0;
                        cnt_q   <= '0;
                        state_q <= ST_MODE;
                    end else begin
                        io_q   <= addr_q[23:20];
                        addr_q <= {addr_q[19:0], 4'h0};
                        cnt_q  <= cnt_q + 16'd1;
                    end
                end

                ST_MODE: begin
                    if (cnt_q == 16'd1) begin
                        en_q    <= EN_NONE;
                        io_q    <= 4'h0;
                        cnt_q   <= '0;
                        state_q <= (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_DUMMY: begin
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == 16'd7) begin
                        cnt_q <= '0;
                        if (words_q == 8'd0) begin
                            csn_q   <= 1'b1;
                            sck_q   <= SCK_IDLE;
                            state_q <= ST_END;
                        end else begin
                            words_q <= words_q - 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_END: begin
                    // An empty capture pipeline means the last data_valid is
                    // on the port this cycle, so ready appears the cycle after.
                    if (cap_vld_q == '0 && cnt_q >= END_HOLD) begin
                        req_ready_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q     <= ST_WAKE_CMD;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b0;
                    csn_q       <= 1'b1;
                    sck_q       <= SCK_IDLE;
                    en_q        <= EN_NONE;
                    io_q        <= '0;
                end
            endcase
        end
    end

    // The nibble index of each data SCK cycle travels down a delay line that
    // matches the pad register latency, so it arrives with its flash_out nibble.
    assign cap_fire = cap_vld_q[CAP_STAGES-1];
    assign cap_sel  = cap_idx_q[CAP_STAGES-1];
    assign cap_last = cap_fire && (cap_sel == 3'd7);

    // Nibble i belongs to byte i/2; even indices are the high nibble.
    // NOTE: asm_d is given its hold value first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        asm_d = asm_q;
        if (cap_fire) begin
            asm_d[{cap_sel[2:1], ~cap_sel[0], 2'b00} +: 4] = flash_out;
        end
    end

    // NOTE: the capture delay line is cleared on reset as well, so a reset in
    // the middle of a word can never release a partial word afterwards.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld_q <= '0;
            for (int i = 0; i < CAP_STAGES; i++) begin
                cap_idx_q[i] <= '0;
            end
            asm_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            cap_vld_q[0] <= (state_q == ST_DATA);
            cap_idx_q[0] <= cnt_q[2:0];
            for (int i = 1; i < CAP_STAGES; i++) begin
                cap_vld_q[i] <= cap_vld_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
            asm_q        <= asm_d;
            data_valid_q <= cap_last;
            if (cap_last) begin
                data_q <= asm_d;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = ~req_ready_q;
    assign data_valid    = data_valid_q;
    assign data          = data_q;
    assign flash_clk_ddr = sck_q;
    assign flash_csn     = csn_q;
    assign flash_in_en   = en_q;
    assign flash_in      = io_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// ----------------------------------------------------------------------------
// tb_qspi_flash_reader
//
// Directed bench for qspi_flash_reader. A small flash model decodes the pad
// activity and returns memory nibbles with a two-cycle input latency. Read
// requests push their expected words and strobe cycles into a scoreboard
// queue; an independent monitor pops and compares on every data_valid.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qspi_flash_reader;

    localparam int DUMMY    = 4;
    localparam int IN_LAT   = 2;
    localparam int WAKE     = 64;
    localparam int CSN_MIN  = 2;

    logic        clk_2x;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_words;
    logic        data_valid;
    logic [31:0] data;
    logic        busy;
    logic [1:0]  flash_clk_ddr;
    logic        flash_csn;
    logic [3:0]  flash_in_en;
    logic [3:0]  flash_in;
    logic [3:0]  flash_out;

    qspi_flash_reader #(
        .DUMMY_CYCLES  (DUMMY),
        .INPUT_LATENCY (IN_LAT),
        .WAKE_DELAY    (WAKE),
        .CSN_HIGH_MIN  (CSN_MIN)
    ) dut (
        .clk_2x        (clk_2x),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_words     (req_words),
        .data_valid    (data_valid),
        .data          (data),
        .busy          (busy),
        .flash_clk_ddr (flash_clk_ddr),
        .flash_csn     (flash_csn),
        .flash_in_en   (flash_in_en),
        .flash_in      (flash_in),
        .flash_out     (flash_out)
    );

    initial clk_2x = 1'b0;
    always #5 clk_2x = ~clk_2x;

    // Cycle m is the interval that ends at the posedge where cyc goes m -> m+1.
    int cyc = 0;
    always @(posedge clk_2x) cyc++;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash memory contents: the spec word at 0x123456, a pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h123456: return 8'hEF;
            24'h123457: return 8'hBE;
            24'h123458: return 8'hAD;
            24'h123459: return 8'hDE;
            default:    return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Flash model
    // ------------------------------------------------------------------
    int          sck_n      = 0;
    int          m_sck_last = 0;
    int          m_rise_cyc = 0;
    int          high_cnt   = 0;
    int          m_min_high = 1000;
    logic [7:0]  m_cmd      = '0;
    logic [23:0] m_addr     = '0;
    logic [7:0]  m_mode     = '0;
    bit          m_io23_ok  = 1'b1;
    bit          m_en_ok    = 1'b1;
    logic        csn_prev   = 1'b1;
    logic [3:0]  pipe1      = 4'h5;
    logic [3:0]  pipe2      = 4'h5;

    initial flash_out = 4'h5;

    always @(negedge clk_2x) begin
        logic [3:0]  nib;
        logic [23:0] ba;
        logic [7:0]  b;
        int          d;
        nib = 4'h5;
        if (flash_csn) begin
            if (!csn_prev) begin
                m_rise_cyc = cyc;
                m_sck_last = sck_n;
            end
            high_cnt++;
            sck_n = 0;
        end else begin
            if (csn_prev) begin
                if (high_cnt < m_min_high) m_min_high = high_cnt;
                high_cnt  = 0;
                m_cmd     = '0;
                m_addr    = '0;
                m_mode    = '0;
                m_io23_ok = 1'b1;
                m_en_ok   = 1'b1;
            end
            if (flash_clk_ddr == 2'b10) begin
                if (sck_n < 8) begin
                    m_cmd = {m_cmd[6:0], flash_in[0]};
                    if (flash_in[3:2] != 2'b11 || flash_in_en != 4'b1101) m_io23_ok = 1'b0;
                end else if (sck_n < 14) begin
                    m_addr = {m_addr[19:0], flash_in};
                    if (flash_in_en != 4'hF) m_en_ok = 1'b0;
                end else if (sck_n < 16) begin
                    m_mode = {m_mode[3:0], flash_in};
                    if (flash_in_en != 4'hF) m_en_ok = 1'b0;
                end else begin
                    if (flash_in_en != 4'h0) m_en_ok = 1'b0;
                    if (sck_n >= 16 + DUMMY && m_cmd == 8'hEB) begin
                        d   = sck_n - 16 - DUMMY;
                        ba  = m_addr + 24'(d / 2);
                        b   = mem_byte(ba);
                        nib = (d % 2 == 0) ? b[7:4] : b[3:0];
                    end
                end
                sck_n++;
            end
        end
        csn_prev  = flash_csn;
        flash_out = pipe2;
        pipe2     = pipe1;
        pipe1     = nib;
    end

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] word;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];
    int   pushed_count = 0;
    int   dv_count     = 0;

    always @(negedge clk_2x) begin
        exp_t e;
        if (reset_n && data_valid) begin
            dv_count++;
            if (sb.size() == 0) begin
                check("extra_data_valid", dv_count, pushed_count);
            end else begin
                e = sb.pop_front();
                check("data_word", data, e.word);
                check("data_valid_cycle", cyc, e.at_cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called at a negedge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [23:0] a, input logic [7:0] w, input bit hold, output int t);
        bit   ok;
        exp_t e;
        logic [23:0] wa;
        ok = 1'b0;
        req_addr  = a;
        req_words = w;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_2x);
        end
        check("accept_in_time", ok, 1);
        t = cyc;
        if (ok) begin
            for (int k = 0; k <= int'(w); k++) begin
                wa       = a + 24'(4 * k);
                e.word   = {mem_byte(wa + 24'd3), mem_byte(wa + 24'd2),
                            mem_byte(wa + 24'd1), mem_byte(wa)};
                e.at_cyc = t + 31 + 8 * k;
                sb.push_back(e);
                pushed_count++;
            end
        end
        @(negedge clk_2x);
        check("ready_low_after_accept", req_ready, 0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int rdy);
        bit ok;
        ok  = 1'b0;
        rdy = -1;
        for (int i = 0; i < 4000; i++) begin
            if (req_ready) begin
                ok  = 1'b1;
                rdy = cyc;
                break;
            end
            @(negedge clk_2x);
        end
        check("idle_in_time", ok, 1);
    endtask

    // Releases reset and follows the wake sequence to the first ready cycle.
    task automatic wake_check();
        logic [7:0] wbyte;
        int         sck;
        int         rdy_n;
        int         rel;
        int         n;
        bit         io_ok;
        logic       csn9;
        wbyte = '0;
        sck   = 0;
        rdy_n = -1;
        io_ok = 1'b1;
        csn9  = 1'b0;
        repeat (2) @(negedge clk_2x);
        reset_n = 1'b1;
        rel     = cyc;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk_2x);
            n = cyc - rel;
            if (n >= 1 && n <= 8) begin
                if (!flash_csn && flash_clk_ddr == 2'b10) sck++;
                wbyte = {wbyte[6:0], flash_in[0]};
                if (flash_in[3:2] != 2'b11 || flash_in_en != 4'b1101) io_ok = 1'b0;
            end
            if (n == 9) csn9 = flash_csn;
            if (req_ready) begin
                rdy_n = n;
                break;
            end
        end
        check("wake_io0_byte", wbyte, 8'hAB);
        check("wake_sck_count", sck, 8);
        check("wake_io23_high", io_ok, 1);
        check("wake_csn_high_c9", csn9, 1);
        check("wake_model_sck", m_sck_last, 8);
        check("wake_ready_cycle", rdy_n, 73);
    endtask

    localparam logic [45:0] RESET_OUTS = {1'b1, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0};

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int t;
        int t2;
        int t3;
        int rdy;
        int dv0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_words = '0;

        repeat (3) @(negedge clk_2x);
        check("reset_outputs",
              {flash_csn, flash_clk_ddr, flash_in_en, flash_in, req_ready, busy, data_valid, data},
              RESET_OUTS);

        // Wake sequence after reset release.
        wake_check();

        // Single word from 0x123456.
        issue(24'h123456, 8'd0, 1'b0, t);
        wait_idle(rdy);
        check("single_cmd", m_cmd, 8'hEB);
        check("single_addr", m_addr, 24'h123456);
        check("single_mode", m_mode, 8'h00);
        check("single_io23_cmd_en", m_io23_ok, 1);
        check("single_phase_en", m_en_ok, 1);
        check("single_sck_count", m_sck_last, 28);
        check("single_csn_rise", m_rise_cyc - t, 29);
        check("single_ready_after_dv", rdy >= t + 32, 1);
        check("single_sb_drained", sb.size(), 0);

        // Four words from 0x000100, strobes 8 cycles apart.
        dv0 = dv_count;
        issue(24'h000100, 8'd3, 1'b0, t);
        wait_idle(rdy);
        check("quad_dv_count", dv_count - dv0, 4);
        check("quad_sb_drained", sb.size(), 0);

        // 256 words: full count, no wrap or extra word.
        dv0 = dv_count;
        issue(24'h00FF80, 8'd255, 1'b0, t);
        wait_idle(rdy);
        check("long_dv_count", dv_count - dv0, 256);
        check("long_sck_count", m_sck_last, 20 + 256 * 8);
        check("long_sb_drained", sb.size(), 0);

        // req_valid held high across three back-to-back requests.
        dv0        = dv_count;
        m_min_high = 1000;
        issue(24'h001000, 8'd0, 1'b1, t);
        issue(24'h002000, 8'd1, 1'b1, t2);
        issue(24'h003000, 8'd0, 1'b0, t3);
        wait_idle(rdy);
        check("b2b_gap_1", t2 - t >= 32, 1);
        check("b2b_gap_2", t3 - t2 >= 40, 1);
        check("b2b_csn_high_min", m_min_high >= CSN_MIN, 1);
        check("b2b_dv_count", dv_count - dv0, 4);
        check("b2b_sb_drained", sb.size(), 0);

        // Reset asserted during the second of four words.
        issue(24'h000200, 8'd3, 1'b0, t);
        for (int i = 0; i < 100 && cyc < t + 32; i++) @(negedge clk_2x);
        check("midreset_pending_words", sb.size(), 3);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              {flash_csn, flash_clk_ddr, flash_in_en, flash_in, req_ready, busy, data_valid, data[31:0] & 32'h0},
              RESET_OUTS);
        pushed_count -= sb.size();
        sb.delete();
        dv0 = dv_count;
        wake_check();
        check("midreset_no_more_dv", dv_count - dv0, 0);

        // Normal read after recovery.
        issue(24'h123456, 8'd0, 1'b0, t);
        wait_idle(rdy);
        check("recover_sb_drained", sb.size(), 0);

        repeat (4) @(negedge clk_2x);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
